encoder_speed_window: RTL and testbench

ENCODER_SPEED_WINDOW -- requirements
Module: encoder_speed_window

---
 rtl/encoder_speed_window_pkg.sv | 49 ++++
 rtl/encoder_speed_window_input_cond.sv | 56 +++++
 rtl/encoder_speed_window.sv | 223 ++++++++++++++++++++++
 tb/tb_encoder_speed_window.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_speed_window_pkg.sv
// Shared definitions for the quadrature speed-window block: Gray-code state
// constants, decoded step kinds, start-up phases and the transition decoder.
package encoder_speed_window_pkg;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    typedef enum logic {
        PH_PRIME = 1'b0,
        PH_RUN   = 1'b1
    } phase_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00, channel A in the MSB.
    function automatic logic [1:0] next_fwd(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            QS_00:   n = QS_01;
            QS_01:   n = QS_11;
            QS_11:   n = QS_10;
            QS_10:   n = QS_00;
            default: n = QS_00;
        endcase
        return n;
    endfunction

    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        if (prev == cur) begin
            s = STEP_NONE;
        end else if (cur == next_fwd(prev)) begin
            s = STEP_FWD;
        end else if (prev == next_fwd(cur)) begin
            s = STEP_REV;
        end else begin
            s = STEP_ILLEGAL;
        end
        return s;
    endfunction

endpackage

// File: rtl/encoder_speed_window_input_cond.sv
// enc_input_cond: multi-stage synchronizer for one encoder channel, followed by
// a stability filter when ENC_GLITCH_FILTER_EN is defined.
module enc_input_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    if (SYNC_STAGES < 2 || FILT_CYCLES < 1) begin : g_param_check
        $error("enc_input_cond: SYNC_STAGES must be >= 2 and FILT_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_r;

    // Synchronizer shift chain, oldest sample in the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic [FW-1:0] filt_cnt_r;
    logic          filt_r;

    // A new level is accepted only after FILT_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_r <= '0;
            filt_r     <= 1'b0;
        end else if (sync_r[SYNC_STAGES-1] == filt_r) begin
            filt_cnt_r <= '0;
            filt_r     <= filt_r;
        end else if (filt_cnt_r == FW'(FILT_CYCLES - 1)) begin
            filt_cnt_r <= '0;
            filt_r     <= sync_r[SYNC_STAGES-1];
        end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
            filt_r     <= filt_r;
        end
    end

    assign dout = filt_r;
`else
    assign dout = sync_r[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/encoder_speed_window.sv
// Quadrature encoder x4 decoder with fixed-length measurement windows, saturating
// signed step count and per-window overflow/illegal flags. Optional input glitch
// filtering is enabled by defining ENC_GLITCH_FILTER_EN.
module encoder_speed_window
    import encoder_speed_window_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_CYCLES  = 254,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enc_a,
    input  logic                    enc_b,
    output logic signed [CNT_W-1:0] count_out,
    output logic                    count_valid,
    output logic                    dir,
    output logic                    ovf,
    output logic                    err
);

    if (WIN_CYCLES < 2 || WIN_CYCLES > (1 << 24) || CNT_W < 2) begin : g_param_check
        $error("encoder_speed_window: WIN_CYCLES must be 2..2^24 and CNT_W >= 2");
    end

    localparam int WIN_W        = $clog2(WIN_CYCLES);
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);

    localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] ACC_ONE = CNT_W'(1);

    logic                    a_s;
    logic                    b_s;
    logic [1:0]              cur_s;
    logic [1:0]              prev_r;
    phase_t                  phase_r;
    phase_t                  phase_next_s;
    logic [PRIME_W-1:0]      prime_cnt_r;
    logic                    primed_s;
    step_t                   step_s;
    logic [WIN_W-1:0]        win_cnt_r;
    logic                    terminal_s;
    logic signed [CNT_W-1:0] acc_r;
    logic signed [CNT_W-1:0] acc_next_s;
    logic                    clip_s;
    logic                    illegal_s;
    logic                    ovf_flag_r;
    logic                    err_flag_r;

    enc_input_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_cond_a (
        .clk  (clk),
        .rst  (rst),
        .din  (enc_a),
        .dout (a_s)
    );

    enc_input_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_cond_b (
        .clk  (clk),
        .rst  (rst),
        .din  (enc_b),
        .dout (b_s)
    );

    assign cur_s = {a_s, b_s};

    // Start-up phase register; decoding stays off until the synchronizers hold real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= PH_PRIME;
        end else begin
            phase_r <= phase_next_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt_r <= '0;
        end else if (phase_r == PH_PRIME) begin
            prime_cnt_r <= prime_cnt_r + PRIME_W'(1);
        end else begin
            prime_cnt_r <= prime_cnt_r;
        end
    end

    always_comb begin
        phase_next_s = phase_r;
        case (phase_r)
            PH_PRIME: begin
                if (prime_cnt_r == PRIME_W'(PRIME_CYCLES - 1)) begin
                    phase_next_s = PH_RUN;
                end else begin
                    phase_next_s = PH_PRIME;
                end
            end
            PH_RUN:  phase_next_s = PH_RUN;
            default: phase_next_s = PH_PRIME;
        endcase
    end

    always_comb begin
        primed_s = 1'b0;
        case (phase_r)
            PH_RUN:  primed_s = 1'b1;
            default: primed_s = 1'b0;
        endcase
    end

    // Previous state tracks the input even while priming, so the first decode sees no jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= QS_00;
        end else begin
            prev_r <= cur_s;
        end
    end

    always_comb begin
        step_s = STEP_NONE;
        if (primed_s) begin
            step_s = decode_step(prev_r, cur_s);
        end else begin
            step_s = STEP_NONE;
        end
    end

    // Saturating next accumulator value; a clipped step only raises the overflow flag.
    always_comb begin
        acc_next_s = acc_r;
        clip_s     = 1'b0;
        case (step_s)
            STEP_FWD: begin
                if (acc_r == ACC_MAX) begin
                    clip_s = 1'b1;
                end else begin
                    acc_next_s = acc_r + ACC_ONE;
                end
            end
            STEP_REV: begin
                if (acc_r == ACC_MIN) begin
                    clip_s = 1'b1;
                end else begin
                    acc_next_s = acc_r - ACC_ONE;
                end
            end
            default: begin
                acc_next_s = acc_r;
                clip_s     = 1'b0;
            end
        endcase
    end

    assign illegal_s  = (step_s == STEP_ILLEGAL);
    assign terminal_s = (win_cnt_r == WIN_W'(WIN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_r <= '0;
        end else if (terminal_s) begin
            win_cnt_r <= '0;
        end else begin
            win_cnt_r <= win_cnt_r + WIN_W'(1);
        end
    end

    // Window accumulator and flags restart empty after the terminal cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= '0;
            ovf_flag_r <= 1'b0;
            err_flag_r <= 1'b0;
        end else if (terminal_s) begin
            acc_r      <= '0;
            ovf_flag_r <= 1'b0;
            err_flag_r <= 1'b0;
        end else begin
            acc_r      <= acc_next_s;
            ovf_flag_r <= ovf_flag_r | clip_s;
            err_flag_r <= err_flag_r | illegal_s;
        end
    end

    // Result registers include the terminal cycle's own step and events.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out   <= '0;
            count_valid <= 1'b0;
            ovf         <= 1'b0;
            err         <= 1'b0;
        end else if (terminal_s) begin
            count_out   <= acc_next_s;
            count_valid <= 1'b1;
            ovf         <= ovf_flag_r | clip_s;
            err         <= err_flag_r | illegal_s;
        end else begin
            count_out   <= count_out;
            count_valid <= 1'b0;
            ovf         <= ovf;
            err         <= err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir <= 1'b0;
        end else if (step_s == STEP_FWD) begin
            dir <= 1'b1;
        end else if (step_s == STEP_REV) begin
            dir <= 1'b0;
        end else begin
            dir <= dir;
        end
    end

endmodule

// File: tb/tb_encoder_speed_window.sv
// Self-checking bench for encoder_speed_window: a 16-cycle-window instance and a
// 300-cycle-window instance share stimulus and are compared to a behavioural model.
module tb_encoder_speed_window;

    localparam int CW   = 8;
    localparam int WIN0 = 16;
    localparam int WIN1 = 300;
    localparam int SYNC = 2;
    localparam int FILT = 4;

    logic clk = 1'b0;
    logic rst;
    logic enc_a;
    logic enc_b;

    logic signed [CW-1:0] count0, count1;
    logic valid0, valid1, dir0, dir1, ovf0, ovf1, err0, err1;

    int errors = 0;
    int checks = 0;
    int enc_pos = 0;

    always #5 clk = ~clk;

    encoder_speed_window #(.CNT_W(CW), .WIN_CYCLES(WIN0), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT)) dut0 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
        .count_out(count0), .count_valid(valid0), .dir(dir0), .ovf(ovf0), .err(err0)
    );

    encoder_speed_window #(.CNT_W(CW), .WIN_CYCLES(WIN1), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT)) dut1 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
        .count_out(count1), .count_valid(valid1), .dir(dir1), .ovf(ovf1), .err(err1)
    );

    function automatic logic [1:0] pos_code(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int code_pos(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // ---------------- behavioural reference model ----------------
    // The decoder sees the pins as sampled SYNC edges earlier; decoding starts
    // on the (SYNC+2)-th edge after reset. Windows close every WIN edges.
    logic [1:0] hist [0:SYNC+1];
    int  m_k;
    int  m_acc   [2];
    bit  m_ovf   [2];
    bit  m_err   [2];
    int  e_count [2];
    bit  e_ovf   [2];
    bit  e_err   [2];
    bit  e_valid [2];
    bit  e_dir;

    always @(posedge clk) begin
        int d, delta, sum, wl;
        bit bad;
        if (rst) begin
            m_k   = 0;
            e_dir = 1'b0;
            foreach (hist[j]) hist[j] = 2'b00;
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 0; m_ovf[i] = 1'b0; m_err[i] = 1'b0;
                e_count[i] = 0; e_ovf[i] = 1'b0; e_err[i] = 1'b0; e_valid[i] = 1'b0;
            end
        end else begin
            for (int j = SYNC + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {enc_a, enc_b};
            m_k++;
            delta = 0;
            bad   = 1'b0;
            if (m_k >= SYNC + 2) begin
                d = (code_pos(hist[SYNC]) - code_pos(hist[SYNC+1]) + 4) % 4;
                if (d == 1) begin delta = 1;  e_dir = 1'b1; end
                if (d == 3) begin delta = -1; e_dir = 1'b0; end
                if (d == 2) bad = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                wl  = (i == 0) ? WIN0 : WIN1;
                sum = m_acc[i] + delta;
                if (sum > 127)  begin sum = 127;  m_ovf[i] = 1'b1; end
                if (sum < -128) begin sum = -128; m_ovf[i] = 1'b1; end
                m_acc[i] = sum;
                if (bad) m_err[i] = 1'b1;
                e_valid[i] = 1'b0;
                if (m_k % wl == 0) begin
                    e_count[i] = m_acc[i]; e_ovf[i] = m_ovf[i]; e_err[i] = m_err[i];
                    e_valid[i] = 1'b1;
                    m_acc[i] = 0; m_ovf[i] = 1'b0; m_err[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_pos(input int p);
        enc_pos = (p + 4) % 4;
        {enc_a, enc_b} = pos_code(enc_pos);
    endtask

    task automatic do_steps(input int n, input int delta, input int gap);
        for (int s = 0; s < n; s++) begin
            set_pos(enc_pos + delta);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_strobe(input int inst, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (((inst == 0) ? valid0 : valid1) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first;
        rst = 1'b1;
        set_pos(0);
        repeat (3) @(negedge clk);
        checks++;
        if ({count0, valid0, dir0, ovf0, err0} !== 12'h000) begin
            errors++; $display("FAIL reset_dut0: got %h expected 000", {count0, valid0, dir0, ovf0, err0});
        end
        checks++;
        if ({count1, valid1, dir1, ovf1, err1} !== 12'h000) begin
            errors++; $display("FAIL reset_dut1: got %h expected 000", {count1, valid1, dir1, ovf1, err1});
        end
        rst = 1'b0;
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (valid0 === 1'b1) begin first = n; break; end
        end
        checks++;
        if (first !== WIN0) begin
            errors++; $display("FAIL first_window_len: got %0d expected %0d", first, WIN0);
        end
        checks++;
        if (count0 !== 8'sh00) begin
            errors++; $display("FAIL first_window_count: got %0d expected 0", count0);
        end
    endtask

    task automatic test_forward();
        bit ok;
        wait_strobe(0, 20, ok);
        do_steps(5, 1, 2);
        wait_strobe(0, 20, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL fwd_strobe: got none expected strobe"); end
        checks++;
        if (count0 !== 8'sh05 || count0 !== CW'(e_count[0])) begin
            errors++; $display("FAIL fwd_count: got %0d expected 5 (model %0d)", count0, e_count[0]);
        end
        checks++;
        if ({dir0, ovf0, err0} !== {1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL fwd_flags: got dir/ovf/err %b%b%b expected 100", dir0, ovf0, err0);
        end
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL fwd_single_pulse: got %b expected 0", valid0); end
    endtask

    task automatic test_reverse();
        bit ok;
        wait_strobe(0, 20, ok);
        do_steps(3, -1, 2);
        wait_strobe(0, 20, ok);
        checks++;
        if (ok !== 1'b1 || count0 !== 8'shFD || count0 !== CW'(e_count[0])) begin
            errors++; $display("FAIL rev_count: got %0d expected -3 (model %0d)", count0, e_count[0]);
        end
        checks++;
        if (dir0 !== 1'b0 || dir0 !== e_dir) begin
            errors++; $display("FAIL rev_dir: got %b expected 0", dir0);
        end
    endtask

    task automatic test_terminal();
        bit ok;
        wait_strobe(0, 20, ok);
        repeat (13) @(negedge clk);
        do_steps(1, 1, 0);
        wait_strobe(0, 10, ok);
        checks++;
        if (ok !== 1'b1 || count0 !== 8'sh01 || count0 !== CW'(e_count[0])) begin
            errors++; $display("FAIL terminal_step: got %0d expected 1 (model %0d)", count0, e_count[0]);
        end
        wait_strobe(0, 20, ok);
        checks++;
        if (ok !== 1'b1 || count0 !== 8'sh00 || count0 !== CW'(e_count[0])) begin
            errors++; $display("FAIL terminal_next: got %0d expected 0 (model %0d)", count0, e_count[0]);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        logic dir_before;
        wait_strobe(0, 20, ok);
        dir_before = dir0;
        set_pos(enc_pos + 2);
        wait_strobe(0, 20, ok);
        checks++;
        if (ok !== 1'b1 || count0 !== 8'sh00 || err0 !== 1'b1 || err0 !== e_err[0]) begin
            errors++; $display("FAIL illegal_win: got count %0d err %b expected 0/1", count0, err0);
        end
        checks++;
        if (dir0 !== dir_before) begin
            errors++; $display("FAIL illegal_dir: got %b expected %b", dir0, dir_before);
        end
        wait_strobe(0, 20, ok);
        checks++;
        if (ok !== 1'b1 || err0 !== 1'b0 || count0 !== 8'sh00) begin
            errors++; $display("FAIL illegal_clear: got count %0d err %b expected 0/0", count0, err0);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        wait_strobe(1, 700, ok);
        do_steps(130, 1, 2);
        wait_strobe(1, 100, ok);
        checks++;
        if (ok !== 1'b1 || count1 !== 8'sh7F || ovf1 !== 1'b1 || count1 !== CW'(e_count[1])) begin
            errors++; $display("FAIL sat_high: got %0d ovf %b expected 127/1", count1, ovf1);
        end
        wait_strobe(1, 400, ok);
        checks++;
        if (ok !== 1'b1 || count1 !== 8'sh00 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL sat_idle: got %0d ovf %b expected 0/0", count1, ovf1);
        end
        do_steps(130, 1, 2);
        do_steps(3, -1, 2);
        wait_strobe(1, 100, ok);
        checks++;
        if (ok !== 1'b1 || count1 !== 8'sh7C || ovf1 !== 1'b1 || count1 !== CW'(e_count[1])) begin
            errors++; $display("FAIL sat_back: got %0d ovf %b expected 124/1", count1, ovf1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int first;
        wait_strobe(0, 20, ok);
        do_steps(4, 1, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({count0, valid0, dir0, ovf0, err0} !== 12'h000) begin
            errors++; $display("FAIL midrst_outputs: got %h expected 000", {count0, valid0, dir0, ovf0, err0});
        end
        rst = 1'b0;
        first = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (valid0 === 1'b1) begin first = n; break; end
        end
        checks++;
        if (first !== WIN0) begin
            errors++; $display("FAIL midrst_strobe_at: got %0d expected %0d", first, WIN0);
        end
        checks++;
        if (count0 !== 8'sh00 || ovf0 !== 1'b0 || err0 !== 1'b0) begin
            errors++; $display("FAIL midrst_window: got %0d ovf %b err %b expected 0/0/0", count0, ovf0, err0);
        end
    endtask

    task automatic test_random();
        bit ok;
        int r;
        wait_strobe(0, 20, ok);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (valid0 !== e_valid[0]) begin
                errors++; $display("FAIL rnd_valid cycle %0d: got %b expected %b", c, valid0, e_valid[0]);
            end
            if (valid0 === 1'b1) begin
                checks++;
                if (count0 !== CW'(e_count[0]) || ovf0 !== e_ovf[0] || err0 !== e_err[0] || dir0 !== e_dir) begin
                    errors++;
                    $display("FAIL rnd_window cycle %0d: got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                             c, count0, ovf0, err0, dir0, e_count[0], e_ovf[0], e_err[0], e_dir);
                end
            end
            r = $urandom_range(0, 99);
            if (r < 35)      set_pos(enc_pos + 1);
            else if (r < 70) set_pos(enc_pos - 1);
            else if (r < 74) set_pos(enc_pos + 2);
            else             set_pos(enc_pos);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        wait_strobe(0, 20, ok);
        enc_a = 1'b1;
        repeat (2) @(negedge clk);
        enc_a = 1'b0;
        wait_strobe(0, 20, ok);
        checks++;
        if (ok !== 1'b1 || count0 !== 8'sh00 || err0 !== 1'b0) begin
            errors++; $display("FAIL glitch_ignored: got %0d err %b expected 0/0", count0, err0);
        end
        set_pos(1);
        wait_strobe(0, 20, ok);
        checks++;
        if (ok !== 1'b1 || count0 !== 8'sh01 || dir0 !== 1'b1) begin
            errors++; $display("FAIL glitch_real_step: got %0d dir %b expected 1/1", count0, dir0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        test_reset();
`ifdef ENC_GLITCH_FILTER_EN
        test_glitch();
`else
        test_forward();
        test_reverse();
        test_terminal();
        test_illegal();
        test_saturation();
        test_reset_mid();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
